// File: rtl/mux_scan_seq.sv
// mux_scan_seq
// Registered CH-channel multiplexer with a valid/ready output stage.
// Two modes:
//   - direct: the channel is picked by sel.
//   - scan:   an internal counter walks channels 0..CH-1 round-robin.
// Each sample is tagged with its channel index (out_sel). A last-channel
// marker (out_last) flags a scan sample taken from channel CH-1.
// The held sample is frozen while the downstream stalls.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in         packed channel data; channel k = in[k*W +: W]
//   en         enables sample loads
//   mode       0 = direct (sel), 1 = scan (internal counter)
//   sel        channel index used in direct mode
//   out        registered sample
//   out_sel    channel index of the sample in out
//   out_valid  out/out_sel/out_last hold a sample
//   out_ready  downstream accepts when out_valid && out_ready
//   out_last   sample came from channel CH-1 in scan mode
module mux_scan_seq #(
    parameter int CH    = 16,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH*W-1:0]   in,
    input  logic              en,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      out,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CH - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       out_q, out_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;

    logic [SEL_W-1:0]   cnt_eff_s;
    logic [SEL_W-1:0]   ptr_s;
    logic [W-1:0]       chan_s;
    logic               load_s;

    // Next-state, channel pointer, channel extraction and output-stage update
    always_comb begin
        state_d     = ST_IDLE;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        chan_s      = {W{1'b0}};

        if (!en) begin
            state_d = ST_IDLE;
        end else if (mode) begin
            state_d = ST_SCAN;
        end else begin
            state_d = ST_DIRECT;
        end

        // Entering SCAN restarts the walk at channel 0 in the same cycle,
        // so the first scanned sample is always channel 0.
        if ((state_d == ST_SCAN) && (state_q != ST_SCAN)) begin
            cnt_eff_s = {SEL_W{1'b0}};
        end else begin
            cnt_eff_s = cnt_q;
        end

        case (state_d)
            ST_SCAN:   ptr_s = cnt_eff_s;
            ST_DIRECT: ptr_s = sel;
            default:   ptr_s = sel;
        endcase

        // Only indices 0..CH-1 match, so an out-of-range sel yields zero data.
        for (int k = 0; k < CH; k++) begin
            chan_s = chan_s | ({W{ptr_s == SEL_W'(k)}} & in[k*W +: W]);
        end

        // out_ready reaches only this enable, never the data path.
        load_s = en && (!out_valid_q || out_ready);

        // The clear on SCAN entry is committed even when no load happens.
        cnt_d = cnt_eff_s;

        if (load_s) begin
            out_d       = chan_s;
            out_sel_d   = ptr_s;
            out_valid_d = 1'b1;
            out_last_d  = (state_d == ST_SCAN) && (cnt_eff_s == LAST_IDX);
            if (state_d == ST_SCAN) begin
                if (cnt_eff_s == LAST_IDX) begin
                    cnt_d = {SEL_W{1'b0}};
                end else begin
                    cnt_d = cnt_eff_s + SEL_W'(1);
                end
            end else begin
                cnt_d = cnt_eff_s;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            // Stall: everything holds.
            out_valid_d = out_valid_q;
            out_last_d  = out_last_q;
        end
    end

    // State, scan counter and output-stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {SEL_W{1'b0}};
            out_q       <= {W{1'b0}};
            out_sel_q   <= {SEL_W{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: a 16x1 instance (direct sweep, scan,
// backpressure, enable drain, mid-scan reset) and a 5x8 instance
// (non-power-of-2 scan and out-of-range direct select).
module tb_mux_scan_seq;

    logic        clk;
    logic        rst_n;

    // 16-channel, 1-bit instance
    logic [15:0] a_in;
    logic        a_en, a_mode, a_ready;
    logic [3:0]  a_sel;
    logic [0:0]  a_out;
    logic [3:0]  a_out_sel;
    logic        a_valid, a_last;

    // 5-channel, 8-bit instance
    logic [39:0] b_in;
    logic        b_en, b_mode, b_ready;
    logic [2:0]  b_sel;
    logic [7:0]  b_out;
    logic [2:0]  b_out_sel;
    logic        b_valid, b_last;

    int n_cmp;
    int n_err;

    logic [15:0] pat;
    logic [7:0]  b_exp [0:5];

    mux_scan_seq #(.CH(16), .W(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in(a_in), .en(a_en), .mode(a_mode),
        .sel(a_sel), .out(a_out), .out_sel(a_out_sel), .out_valid(a_valid),
        .out_ready(a_ready), .out_last(a_last)
    );

    mux_scan_seq #(.CH(5), .W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in(b_in), .en(b_en), .mode(b_mode),
        .sel(b_sel), .out(b_out), .out_sel(b_out_sel), .out_valid(b_valid),
        .out_ready(b_ready), .out_last(b_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one full sample on the 16-channel instance against the pattern.
    task automatic chk_a(input string tag, input int ch, input logic last_exp);
        chk({tag, ".out"},   32'(a_out),     32'(pat[ch]));
        chk({tag, ".sel"},   32'(a_out_sel), 32'(ch));
        chk({tag, ".valid"}, 32'(a_valid),   32'd1);
        chk({tag, ".last"},  32'(a_last),    32'(last_exp));
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        pat     = 16'haf82;
        b_exp[0] = 8'h11; b_exp[1] = 8'h22; b_exp[2] = 8'h33;
        b_exp[3] = 8'h44; b_exp[4] = 8'h55; b_exp[5] = 8'h11;

        rst_n   = 1'b1;
        a_in = 16'h0000; a_en = 1'b0; a_mode = 1'b0; a_ready = 1'b1; a_sel = 4'd0;
        b_in = 40'h0;    b_en = 1'b0; b_mode = 1'b0; b_ready = 1'b1; b_sel = 3'd0;

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        chk("rst.a_out",   32'(a_out),     32'd0);
        chk("rst.a_sel",   32'(a_out_sel), 32'd0);
        chk("rst.a_valid", 32'(a_valid),   32'd0);
        chk("rst.a_last",  32'(a_last),    32'd0);
        chk("rst.b_out",   32'(b_out),     32'd0);
        chk("rst.b_valid", 32'(b_valid),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Direct sweep
        a_in = pat; a_en = 1'b1; a_mode = 1'b0; a_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_sel = 4'(i);
            tick();
            chk_a("direct", i, 1'b0);
        end

        // Scan: 34 consecutive samples, counter cleared on entry
        a_mode = 1'b1;
        for (int j = 0; j < 34; j++) begin
            tick();
            chk_a("scan", j % 16, (j % 16) == 15);
        end
        // Continue to channel 5
        for (int j = 2; j <= 5; j++) begin
            tick();
            chk_a("scan2", j, 1'b0);
        end

        // Backpressure: hold channel 5 for three cycles
        a_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk_a("stall", 5, 1'b0);
        end
        a_ready = 1'b1;
        tick();
        chk_a("unstall", 6, 1'b0);

        // Walk on to channel 3 of the next round
        for (int j = 7; j < 20; j++) begin
            tick();
            chk_a("scan3", j % 16, (j % 16) == 15);
        end

        // Enable drop: sample drains, out_sel stays 3
        a_en = 1'b0;
        tick();
        chk("drain.valid", 32'(a_valid),   32'd0);
        chk("drain.sel",   32'(a_out_sel), 32'd3);
        chk("drain.last",  32'(a_last),    32'd0);
        tick();
        chk("idle.valid",  32'(a_valid),   32'd0);

        // Re-enable scan: IDLE->SCAN restarts at channel 0
        a_en = 1'b1;
        tick();
        chk_a("reen", 0, 1'b0);
        for (int j = 1; j <= 9; j++) begin
            tick();
            chk_a("scan4", j, 1'b0);
        end

        // Asynchronous reset mid-scan
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out",   32'(a_out),     32'd0);
        chk("arst.sel",   32'(a_out_sel), 32'd0);
        chk("arst.valid", 32'(a_valid),   32'd0);
        chk("arst.last",  32'(a_last),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_a("post_rst", 0, 1'b0);
        tick();
        chk_a("post_rst", 1, 1'b0);
        a_en = 1'b0;

        // Non-power-of-2: CH=5, W=8 scan
        b_in = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        b_en = 1'b1; b_mode = 1'b1; b_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("np2.out",   32'(b_out),     32'(b_exp[j]));
            chk("np2.sel",   32'(b_out_sel), 32'(j % 5));
            chk("np2.last",  32'(b_last),    32'((j % 5) == 4));
            chk("np2.valid", 32'(b_valid),   32'd1);
        end

        // Direct, in range then out of range
        b_mode = 1'b0; b_sel = 3'd2;
        tick();
        chk("np2d.out", 32'(b_out),     32'h33);
        chk("np2d.sel", 32'(b_out_sel), 32'd2);
        b_sel = 3'd6;
        tick();
        chk("np2x.out",   32'(b_out),     32'h00);
        chk("np2x.sel",   32'(b_out_sel), 32'd6);
        chk("np2x.last",  32'(b_last),    32'd0);
        chk("np2x.valid", 32'(b_valid),   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
